// File: rtl/popcount_seq_ctrl.sv
// Serial popcount sequencer: latches a WIDTH-bit operand on start and counts CHUNK bits per cycle.
// Optional build macro POPCNT_EARLY_EXIT_EN finishes as soon as no set bits remain above the current chunk.
module popcount_seq_ctrl #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    chunk_pc;
  logic             last;

  function automatic logic [CW-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < CHUNK; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  always_comb begin
    shifted  = shreg >> CHUNK;
    chunk_pc = popcnt(shreg[CHUNK-1:0]);
`ifdef POPCNT_EARLY_EXIT_EN
    last     = (idx == LAST_IDX) || (shifted == '0);
`else
    last     = (idx == LAST_IDX);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // start is deliberately not looked at here; a new request waits for IDLE
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      idx   <= '0;
      acc   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shreg <= data_in;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc + chunk_pc;
          shreg <= shifted;
          idx   <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign count = acc;

endmodule
